// File: rtl/layernorm_pkg.sv
// Shared types and constants for the layernorm arbitration slice.
package layernorm_pkg;

  localparam int unsigned NREQ_DEF = 4;
  localparam int unsigned LEN_DEF  = 8;
  localparam int unsigned W_DEF    = 16;
  localparam int unsigned FRAC     = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned ID_W_DEF = id_width(NREQ_DEF);

  typedef logic signed [W_DEF-1:0] elem_t;
  typedef elem_t [LEN_DEF-1:0] vec_t;

  typedef struct packed {
    logic                valid;
    logic [ID_W_DEF-1:0] id;
  } tag_t;

endpackage

// File: rtl/layernorm_arbiter_rr.sv
// Round-robin arbiter: searches from the pointer, grants one requester when enabled.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] cand_idx;
  int unsigned      cand;
  logic             found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    ptr_d     = ptr_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found     = 1'b1;
        grant_idx = cand_idx;
      end
    end
    if (en && found) begin
      grant[grant_idx] = 1'b1;
      ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/layernorm_arbiter.sv
// Shares one fixed-latency layernorm datapath among NREQ requesters with
// credit-based issue, id tagging and an in-order result FIFO.
module layernorm_arbiter
  import layernorm_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned LEN    = LEN_DEF,
  parameter int unsigned W      = W_DEF,
  parameter int unsigned DP_LAT = 1,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned ID_W  = id_width(NREQ),
  localparam int unsigned VEC_W = LEN * W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*VEC_W-1:0] req_vec,
  output logic                 ln_valid_in,
  output logic [VEC_W-1:0]     ln_in_vec,
  input  logic                 ln_valid_out,
  input  logic [VEC_W-1:0]     ln_out_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ID_W-1:0]      out_id,
  output logic [VEC_W-1:0]     out_vec,
  output logic                 busy,
  output logic                 err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + DP_LAT + 1);
  localparam int unsigned PTR_W = id_width(DEPTH);

  logic              can_issue, issue, push, pop, last_v;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   winner;
  logic [CNT_W-1:0]  inflight_q, inflight_d, count_q, count_d;
  logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic              err_q, err_d;
  logic [DP_LAT-1:0] tag_v_q;
  logic [ID_W-1:0]   tag_id_q [DP_LAT];
  logic [ID_W-1:0]   id_mem_q [DEPTH];
  logic [VEC_W-1:0]  vec_mem_q [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credits come from registered counts only, so out_ready never reaches req_ready.
  assign can_issue = !rst && ((count_q + inflight_q) < CNT_W'(DEPTH));

  rr_arbiter #(.NREQ(NREQ), .IDX_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .en        (can_issue),
    .grant     (grant),
    .grant_idx (winner)
  );

  assign issue       = |grant;
  assign req_ready   = grant;
  assign ln_valid_in = issue;

  always_comb begin
    ln_in_vec = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (grant[r]) ln_in_vec = req_vec[r*VEC_W +: VEC_W];
    end
  end

  assign last_v    = tag_v_q[DP_LAT-1];
  assign push      = ln_valid_out & last_v;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign out_id    = id_mem_q[rd_q];
  assign out_vec   = vec_mem_q[rd_q];
  assign busy      = (inflight_q != '0) | (count_q != '0);
  assign err       = err_q;

  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_d       = push ? ptr_next(wr_q) : wr_q;
    rd_d       = pop  ? ptr_next(rd_q) : rd_q;
    // Orphan results and missing results both mismatch the tag: sticky error.
    err_d      = err_q | (ln_valid_out ^ last_v);
    case ({issue, last_v})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q    <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      tag_v_q[0] <= issue;
      for (int unsigned k = 1; k < DP_LAT; k++) tag_v_q[k] <= tag_v_q[k-1];
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q[0] <= winner;
    for (int unsigned k = 1; k < DP_LAT; k++) tag_id_q[k] <= tag_id_q[k-1];
    if (push) begin
      id_mem_q[wr_q]  <= tag_id_q[DP_LAT-1];
      vec_mem_q[wr_q] <= ln_out_vec;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count_q == CNT_W'(DEPTH)));

endmodule
